// File: rtl/m5_query_responder_pkg.sv
// Shared types for the M5 query responder: command codes, table entry layout
// and the responder FSM states.
package m5_query_pkg;

  localparam int ADDR_W = 28;
  localparam int CNT_W  = 13;
  localparam int CMD_W  = 4;

  typedef enum logic [CMD_W-1:0] {
    NOP         = 4'd0,
    QUERY       = 4'd1,
    CLEAR       = 4'd2,
    QUERY_CLEAR = 4'd3
  } query_cmd_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
  } topk_entry_t;

  typedef enum logic {
    IDLE,
    STREAM
  } resp_state_e;

endpackage

// File: rtl/m5_query_responder_if.sv
// Query, migration-address and hotness-update channels between a query
// controller / hotness tracker (master) and the responder (slave).
interface m5_query_responder_if #(
  parameter int ADDR_SIZE = 28,
  parameter int CNT_SIZE  = 13,
  parameter int CMD_WIDTH = 4
);
  logic                 query_en;
  logic [CMD_WIDTH-1:0] query_cmd;
  logic                 query_ready;
  logic                 mig_addr_en;
  logic [ADDR_SIZE-1:0] mig_addr;
  logic                 mig_addr_ready;
  logic                 upd_en;
  logic [ADDR_SIZE-1:0] upd_addr;
  logic [CNT_SIZE-1:0]  upd_cnt;
  logic                 upd_ready;

  modport master (
    output query_en, query_cmd, mig_addr_ready, upd_en, upd_addr, upd_cnt,
    input  query_ready, mig_addr_en, mig_addr, upd_ready
  );

  modport slave (
    input  query_en, query_cmd, mig_addr_ready, upd_en, upd_addr, upd_cnt,
    output query_ready, mig_addr_en, mig_addr, upd_ready
  );
endinterface

// File: rtl/m5_query_responder_topk_min_select.sv
// Combinational argmin over the table counts (lowest index wins a tie), plus
// the lowest-index invalid slot used when inserting a new address.
module topk_min_select
  import m5_query_pkg::*;
#(
  parameter int TOP_K      = 5,
  parameter int TOP_K_BITS = 3
) (
  input  topk_entry_t           entries [TOP_K],
  output logic [TOP_K_BITS-1:0] min_idx,
  output logic [CNT_W-1:0]      min_cnt,
  output logic                  has_free,
  output logic [TOP_K_BITS-1:0] free_idx
);

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    min_idx  = '0;
    min_cnt  = entries[0].cnt;
    has_free = 1'b0;
    free_idx = '0;
    // Strict less-than keeps the earlier slot on equal counts.
    for (int i = 1; i < TOP_K; i++) begin
      if (entries[i].cnt < min_cnt) begin
        min_cnt = entries[i].cnt;
        min_idx = TOP_K_BITS'(i);
      end
    end
    for (int i = 0; i < TOP_K; i++) begin
      if (!has_free && !entries[i].valid) begin
        has_free = 1'b1;
        free_idx = TOP_K_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/m5_query_responder.sv
// Top-K hot-address responder: maintains the table from tracker updates and
// streams valid addresses in slot order in answer to query commands.
module m5_query_responder
  import m5_query_pkg::*;
#(
  parameter int TOP_K      = 5,
  parameter int TOP_K_BITS = 3,
  parameter int ADDR_SIZE  = ADDR_W,
  parameter int CNT_SIZE   = CNT_W,
  parameter int CMD_WIDTH  = CMD_W
) (
  input logic                  clk,
  input logic                  rst,
  m5_query_responder_if.slave  bus
);

  resp_state_e           state;
  logic                  init_done;
  logic                  clr_mode;
  logic [TOP_K_BITS-1:0] ptr;
  topk_entry_t           tbl [TOP_K];

  logic [CMD_WIDTH-1:0]  cmd;
  logic [ADDR_SIZE-1:0]  upd_addr;
  logic [CNT_SIZE-1:0]   upd_cnt;
  logic                  idle_ok, query_fire, upd_fire, start_stream, clear_fire;
  logic                  found, more, beat;
  logic [TOP_K_BITS-1:0] found_idx;
  logic                  match;
  logic [TOP_K_BITS-1:0] match_idx;
  logic [TOP_K_BITS-1:0] min_idx, free_idx;
  logic [CNT_W-1:0]      min_cnt;
  logic                  has_free;

  assign cmd          = bus.query_cmd;
  assign upd_addr     = bus.upd_addr;
  assign upd_cnt      = bus.upd_cnt;
  assign idle_ok      = init_done && (state == IDLE);
  assign query_fire   = bus.query_en && idle_ok;
  assign upd_fire     = bus.upd_en && idle_ok;
  assign start_stream = query_fire && (cmd == QUERY || cmd == QUERY_CLEAR);
  assign clear_fire   = query_fire && (cmd == CLEAR);

  // Priority search from ptr; 'more' flags a second valid slot behind the hit,
  // which lets the FSM leave STREAM right after the final handshake.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    more      = 1'b0;
    for (int i = 0; i < TOP_K; i++) begin
      if (tbl[i].valid && TOP_K_BITS'(i) >= ptr) begin
        if (found) begin
          more = 1'b1;
        end else begin
          found     = 1'b1;
          found_idx = TOP_K_BITS'(i);
        end
      end
    end
  end

  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < TOP_K; i++) begin
      if (!match && tbl[i].valid && tbl[i].addr == upd_addr) begin
        match     = 1'b1;
        match_idx = TOP_K_BITS'(i);
      end
    end
  end

  topk_min_select #(
    .TOP_K      (TOP_K),
    .TOP_K_BITS (TOP_K_BITS)
  ) u_min_select (
    .entries  (tbl),
    .min_idx  (min_idx),
    .min_cnt  (min_cnt),
    .has_free (has_free),
    .free_idx (free_idx)
  );

  assign bus.query_ready = idle_ok;
  assign bus.upd_ready   = idle_ok;
  assign bus.mig_addr_en = (state == STREAM) && found;
  assign bus.mig_addr    = bus.mig_addr_en ? tbl[found_idx].addr : '0;
  assign beat            = bus.mig_addr_en && bus.mig_addr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      init_done <= 1'b0;
      clr_mode  <= 1'b0;
      ptr       <= '0;
    end else begin
      init_done <= 1'b1;
      case (state)
        IDLE: begin
          if (start_stream) begin
            state    <= STREAM;
            ptr      <= '0;
            clr_mode <= (cmd == QUERY_CLEAR);
          end
        end
        STREAM: begin
          if (!found) begin
            state <= IDLE;
          end else if (beat) begin
            ptr <= found_idx + 1'b1;
            if (!more) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the table is a handful of registers that must come up empty, so it
  // takes the async reset like any other state rather than being left as RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TOP_K; i++) tbl[i] <= '0;
    end else if (clear_fire) begin
      for (int i = 0; i < TOP_K; i++) tbl[i].valid <= 1'b0;
    end else begin
      if (upd_fire) begin
        if (match) begin
          if (upd_cnt > tbl[match_idx].cnt) tbl[match_idx].cnt <= upd_cnt;
        end else if (has_free) begin
          tbl[free_idx] <= '{valid: 1'b1, addr: upd_addr, cnt: upd_cnt};
        end else if (upd_cnt > min_cnt) begin
          tbl[min_idx] <= '{valid: 1'b1, addr: upd_addr, cnt: upd_cnt};
        end
      end
      if (beat && clr_mode) tbl[found_idx].valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m5_query_responder.sv
// Self-checking bench for m5_query_responder: directed scenarios, a table of
// update vectors and randomized traffic against a behavioural table model.
module tb_m5_query_responder;
  import m5_query_pkg::*;

  localparam int K = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  m5_query_responder_if intf ();

  m5_query_responder #(
    .TOP_K      (K),
    .TOP_K_BITS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  // Behavioural model of the table contents.
  bit          mv [K];
  logic [27:0] ma [K];
  logic [12:0] mc [K];

  typedef struct {
    logic [27:0] addr;
    logic [12:0] cnt;
    int          exp_slot;  // slot that ends up holding addr, -1 when dropped
  } upd_vec_t;

  upd_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < K; i++) mv[i] = 1'b0;
  endfunction

  function automatic void model_update(input logic [27:0] a, input logic [12:0] c);
    int m;
    for (int i = 0; i < K; i++) begin
      if (mv[i] && ma[i] == a) begin
        if (c > mc[i]) mc[i] = c;
        return;
      end
    end
    for (int i = 0; i < K; i++) begin
      if (!mv[i]) begin
        mv[i] = 1'b1; ma[i] = a; mc[i] = c;
        return;
      end
    end
    m = 0;
    for (int i = 1; i < K; i++) if (mc[i] < mc[m]) m = i;
    if (c > mc[m]) begin
      ma[m] = a; mc[m] = c;
    end
  endfunction

  function automatic void model_list(output logic [27:0] q [$]);
    q = {};
    for (int i = 0; i < K; i++) if (mv[i]) q.push_back(ma[i]);
  endfunction

  task automatic do_update(input logic [27:0] a, input logic [12:0] c);
    check("upd_ready", 32'(intf.upd_ready), 32'd1);
    intf.upd_en   = 1'b1;
    intf.upd_addr = a;
    intf.upd_cnt  = c;
    @(posedge clk); #1;
    intf.upd_en = 1'b0;
    model_update(a, c);
  endtask

  // Issue a command (optionally with a same-cycle update) and follow the stream.
  // stall_mode: 0 always ready, 1 ready low for the first 3 stream cycles, 2 random.
  task automatic run_stream(input logic [3:0] cmd, input bit with_upd,
                            input logic [27:0] ua, input logic [12:0] uc,
                            input int stall_mode, input logic [27:0] exp [$]);
    int idx, stalls, scyc;
    bit rdy, prev_stall;
    logic [27:0] prev_addr;
    check("query_ready_idle", 32'(intf.query_ready), 32'd1);
    intf.query_en  = 1'b1;
    intf.query_cmd = cmd;
    if (with_upd) begin
      intf.upd_en   = 1'b1;
      intf.upd_addr = ua;
      intf.upd_cnt  = uc;
    end
    @(posedge clk); #1;
    intf.query_en = 1'b0;
    intf.upd_en   = 1'b0;
    if (!(cmd == 4'd1 || cmd == 4'd3)) begin
      check("query_ready_after_cmd", 32'(intf.query_ready), 32'd1);
      check("no_beat_after_cmd", 32'(intf.mig_addr_en), 32'd0);
      return;
    end
    check("stream_entered", 32'(intf.query_ready), 32'd0);
    check("first_beat_en", 32'(intf.mig_addr_en), 32'(exp.size() > 0));
    idx = 0; stalls = 0; scyc = 0; prev_stall = 1'b0; prev_addr = '0;
    while (intf.query_ready == 1'b0 && scyc < 200) begin
      scyc++;
      case (stall_mode)
        1:       rdy = (scyc > 3);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      intf.mig_addr_ready = rdy;
      if (prev_stall) begin
        check("hold_en", 32'(intf.mig_addr_en), 32'd1);
        check("hold_addr", 32'(intf.mig_addr), 32'(prev_addr));
      end
      if (intf.mig_addr_en) begin
        if (idx < exp.size()) check("beat_addr", 32'(intf.mig_addr), 32'(exp[idx]));
        else                  check("beat_overrun", 32'(idx), 32'(exp.size() - 1));
        if (rdy) idx++;
        else     stalls++;
        prev_stall = !rdy;
        prev_addr  = intf.mig_addr;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
    end
    intf.mig_addr_ready = 1'b0;
    check("stream_terminates", 32'(scyc < 200), 32'd1);
    check("beat_count", 32'(idx), 32'(exp.size()));
    check("stream_cycles", 32'(scyc), 32'(exp.size() == 0 ? 1 : exp.size() + stalls));
  endtask

  // Model-driven command: predicts the stream and updates the model afterwards.
  task automatic model_cmd(input logic [3:0] cmd, input bit with_upd,
                           input logic [27:0] ua, input logic [12:0] uc, input int stall_mode);
    logic [27:0] q [$];
    if (with_upd && cmd != 4'd2) model_update(ua, uc);
    model_list(q);
    run_stream(cmd, with_upd, ua, uc, stall_mode, q);
    if (cmd == 4'd2 || cmd == 4'd3) model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] tslot [K];
    logic [27:0] q [$];

    intf.query_en = 1'b0; intf.query_cmd = '0; intf.mig_addr_ready = 1'b0;
    intf.upd_en = 1'b0; intf.upd_addr = '0; intf.upd_cnt = '0;
    model_clear();
    for (int i = 0; i < K; i++) begin ma[i] = '0; mc[i] = '0; end

    vecs[0] = '{28'h1,  13'd4, 0};
    vecs[1] = '{28'h2,  13'd7, 1};
    vecs[2] = '{28'h3,  13'd2, 2};
    vecs[3] = '{28'h4,  13'd9, 3};
    vecs[4] = '{28'h5,  13'd6, 4};
    vecs[5] = '{28'hAA, 13'd3, 2};
    vecs[6] = '{28'hBB, 13'd2, -1};

    // Reset state and init flag.
    repeat (3) @(posedge clk);
    #1;
    check("rst_query_ready", 32'(intf.query_ready), 32'd0);
    check("rst_upd_ready", 32'(intf.upd_ready), 32'd0);
    check("rst_mig_en", 32'(intf.mig_addr_en), 32'd0);
    check("rst_mig_addr", 32'(intf.mig_addr), 32'd0);
    #1 rst = 1'b0;
    #1 check("init_hold_ready", 32'(intf.query_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_init", 32'(intf.upd_ready), 32'd1);

    // Two updates, then a plain query.
    do_update(28'h10, 13'd5);
    do_update(28'h20, 13'd9);
    q = {28'h10, 28'h20};
    run_stream(4'd1, 1'b0, '0, '0, 0, q);

    // Table vectors: fill, replace the minimum, drop a weak update.
    model_cmd(4'd2, 1'b0, '0, '0, 0);
    for (int i = 0; i < K; i++) tslot[i] = '0;
    foreach (vecs[v]) begin
      do_update(vecs[v].addr, vecs[v].cnt);
      if (vecs[v].exp_slot >= 0) tslot[vecs[v].exp_slot] = vecs[v].addr;
    end
    q = {};
    for (int i = 0; i < K; i++) q.push_back(tslot[i]);
    run_stream(4'd1, 1'b0, '0, '0, 0, q);

    // Back-pressure on the first beat.
    run_stream(4'd1, 1'b0, '0, '0, 1, q);

    // QUERY_CLEAR drains three entries; the next QUERY finds nothing.
    model_cmd(4'd2, 1'b0, '0, '0, 0);
    do_update(28'h100, 13'd1);
    do_update(28'h200, 13'd2);
    do_update(28'h300, 13'd3);
    q = {28'h100, 28'h200, 28'h300};
    run_stream(4'd3, 1'b0, '0, '0, 0, q);
    model_clear();
    q = {};
    run_stream(4'd1, 1'b0, '0, '0, 0, q);

    // Reset after the first beat of a four-entry stream.
    do_update(28'h11, 13'd1);
    do_update(28'h22, 13'd2);
    do_update(28'h33, 13'd3);
    do_update(28'h44, 13'd4);
    intf.query_en = 1'b1; intf.query_cmd = 4'd1;
    @(posedge clk); #1;
    intf.query_en = 1'b0; intf.mig_addr_ready = 1'b1;
    check("mid_rst_first_beat", 32'(intf.mig_addr), 32'h11);
    @(posedge clk); #1;
    check("mid_rst_second_beat", 32'(intf.mig_addr), 32'h22);
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(intf.mig_addr_en), 32'd0);
    check("mid_rst_addr", 32'(intf.mig_addr), 32'd0);
    check("mid_rst_qready", 32'(intf.query_ready), 32'd0);
    intf.mig_addr_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    model_cmd(4'd1, 1'b0, '0, '0, 0);

    // Randomized traffic: small address pool so matches and replacements occur.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) < 2) begin
        do_update(28'($urandom_range(0, 15)), 13'($urandom_range(0, 40)));
      end else begin
        model_cmd(4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                  28'($urandom_range(0, 15)), 13'($urandom_range(0, 40)), 2);
      end
    end
    model_cmd(4'd1, 1'b0, '0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
